// File: rtl/timer_arbiter.sv
// Shared prescaled countdown timer: round-robin grants one requester at a time,
// counts its latched delay in prescaler ticks and returns a one-cycle done pulse.
module timer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DLY_W    = 8,
    parameter int PRESCALE = 20000
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DLY_W-1:0] dly_ticks,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic                     tick
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PRE_W = 16;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_rr;
    logic [PRE_W-1:0]   r_pre;
    logic [DLY_W-1:0]   r_rem;

    logic               w_found;
    logic               w_hit;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_rr_next;
    logic [DLY_W-1:0]   w_dly_sel;
    logic               w_req_g;
    logic               w_tick;

    // Round-robin search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j       = (int'(r_rr) + k) % NUM_REQ;
            w_hit   = !w_found && req[j];
            w_pick  = w_hit ? IDX_W'(j) : w_pick;
            w_found = w_found | w_hit;
        end
        w_dly_sel = dly_ticks[int'(w_pick)*DLY_W +: DLY_W];
    end

    // Pointer advances past the winner so it cannot win twice in a row.
    always_comb begin
        if (w_pick == IDX_LAST) begin
            w_rr_next = '0;
        end else begin
            w_rr_next = w_pick + IDX_W'(1);
        end
    end

    assign w_req_g = req[r_idx];
    // Tick only where the countdown actually steps (no abort, not yet expired).
    assign w_tick  = (r_state == S_RUN) && w_req_g && (r_rem != '0) && (r_pre == PRE_MAX);

    // Arbitration and countdown state machine.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_rr    <= '0;
            r_pre   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= '0;
                    if (w_found) begin
                        r_grant <= ONE_HOT0 << w_pick;
                        r_idx   <= w_pick;
                        r_rem   <= w_dly_sel;
                        r_pre   <= '0;
                        r_rr    <= w_rr_next;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!w_req_g) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_rem == '0) begin
                        r_done  <= r_grant;
                        r_state <= S_DONE;
                    end else if (r_pre == PRE_MAX) begin
                        r_pre <= '0;
                        r_rem <= r_rem - DLY_W'(1);
                    end else begin
                        r_pre <= r_pre + PRE_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= '0;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant = r_grant;
    assign done  = r_done;
    assign busy  = r_busy;
    assign tick  = w_tick;

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one prescaled countdown timer among NUM_REQ requesters, for example the lockout timer, the keypad debounce timer and the LED blink timer in the lock.
- Round-robin arbitration selects one requester at a time.
- The granted requester's delay, in prescaler ticks, is latched and counted down. A one-cycle done pulse is returned to that requester.
- Sits between the lock FSMs and the system clock. It replaces the per-consumer clock dividers with a single clock-enable-based timer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DLY_W, 8, width of each requester's delay field, in ticks.
- PRESCALE, 20000, terminal value of the prescaler. Tick period is PRESCALE+1 clk_in cycles. Fits in 16 bits.

Ports:
- clk_in, input, 1, system clock.
- rst, input, 1, reset.
- req, input, NUM_REQ, level request per requester. Must be held until done or abandoned.
- dly_ticks, input, NUM_REQ*DLY_W, delay per requester. Requester i uses bits [i*DLY_W +: DLY_W].
- grant, output, NUM_REQ, one-hot grant. All zero when idle.
- done, output, NUM_REQ, one-cycle completion pulse to the granted requester.
- busy, output, 1, high while in RUN or DONE.
- tick, output, 1, one-cycle pulse each time the prescaler wraps while in RUN.

Behaviour:
- Reset is asynchronous and active-high on rst; the clock is clk_in. All logic is on posedge clk_in.
- Reset values:
  - state=IDLE, grant=0, done=0, busy=0, tick=0.
  - prescaler=0, remaining=0, rr pointer=0.
- States:
  - IDLE: if req != 0, pick the first set bit searching from the rr pointer upward, wrapping modulo NUM_REQ. In the next cycle: grant is one-hot for that index, remaining is latched from that requester's dly_ticks, prescaler=0, state=RUN, and rr pointer = index+1 mod NUM_REQ.
  - RUN, evaluated in this priority order:
    - (a) If req[granted] is low: abort. Next cycle is IDLE with grant=0 and no done pulse.
    - (b) Else if remaining==0: go to DONE.
    - (c) Else if prescaler==PRESCALE: prescaler<=0, remaining<=remaining-1, tick=1 for that cycle.
    - (d) Else prescaler<=prescaler+1.
  - DONE: done[granted]=1 for exactly this cycle, and grant stays asserted. The next state is always IDLE with grant=0, regardless of req.
- Latency:
  - Grant rises 1 cycle after req is seen in IDLE.
  - For delay D, done is high in cycle D*(PRESCALE+1)+1, counting the first grant cycle as cycle 0.
  - D=0 gives done in cycle 1.
- dly_ticks is sampled only at grant. Later changes have no effect on the running count.
- Back-to-back operation:
  - After DONE there is one IDLE cycle.
  - Next grant is 2 cycles after the done cycle.
  - A requester that keeps req high after done is re-arbitrated like any other and does not win consecutively if others are waiting.
- Requests arriving during RUN/DONE are held off until IDLE. They are not queued beyond the level req.
- busy = (state != IDLE).
- grant and done are never asserted for more than one index.
- done is never asserted without grant.
- rst mid-RUN returns to reset values immediately. No done pulse is issued.
- Prescaler and remaining do not wrap: remaining is never decremented below 0.

Test Plan:
All scenarios use PRESCALE=3, NUM_REQ=4, DLY_W=8.

1. Reset and first grant
   - Stimulus: hold rst for 3 cycles, release, keep req=0 for 5 cycles, then req=4'b0010 with dly[1]=2.
   - Required response:
     - All outputs stay 0 until the request arrives.
     - Grant=0010 one cycle after req rises.
     - tick pulses at grant cycles 3 and 7.
     - done[1] at cycle 9.
     - Grant drops at cycle 10.
2. Zero delay
   - Stimulus: req=0001 with dly[0]=0.
   - Required response:
     - Grant in cycle 0.
     - done[0]=1 in cycle 1, with no tick.
     - IDLE in cycle 2.
3. Round-robin fairness
   - Stimulus: req=1111 held continuously, all dly=1.
   - Required response:
     - Grant order is 0,1,2,3,0.
     - Each done comes 5 cycles after its grant.
     - Consecutive grants are spaced 7 cycles apart.
4. Abort
   - Stimulus: req=0100 with dly[2]=5; drop req[2] at grant cycle 6.
   - Required response:
     - Grant=0 at cycle 7.
     - done is never asserted.
     - busy=0 at cycle 7.
5. Reset mid-operation and latch check
   - Stimulus: req=1000 with dly[3]=3; change dly[3] to 1 at grant cycle 2; pulse rst at grant cycle 6.
   - Required response:
     - Before the reset, tick occurs at cycle 3.
     - The changed dly has no effect on the running count.
     - After the reset pulse, all outputs are 0 and no done pulse is issued.
     - With req still high after rst release, grant=1000 occurs again 1 cycle after release.
